// File: rtl/harvos_satp_pkg.sv
// Shared satp field layout, the single supported translation MODE and the
// sequencer state encoding.
package harvos_satp_pkg;

    localparam int SATP_PPN_LSB  = 0;
    localparam int SATP_PPN_W    = 22;
    localparam int SATP_ASID_LSB = SATP_PPN_LSB + SATP_PPN_W;
    localparam int SATP_ASID_W   = 6;
    localparam int SATP_MODE_LSB = SATP_ASID_LSB + SATP_ASID_W;
    localparam int SATP_MODE_W   = 4;
    localparam int SATP_CTX_W    = SATP_ASID_W + SATP_PPN_W;

    localparam logic [SATP_MODE_W-1:0] SATP_MODE_SV = 4'd1;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_DRAIN,
        SEQ_FLUSH,
        SEQ_COMMIT,
        SEQ_ABORT
    } satp_seq_state_e;

    // Translation context (ASID+PPN) is everything below MODE.
    function automatic logic [31:0] satp_pack(input logic [SATP_MODE_W-1:0] mode,
                                              input logic [SATP_CTX_W-1:0]  ctx);
        return {mode, ctx};
    endfunction

endpackage

// File: rtl/tlb_flush_tracker.sv
// Request/acknowledge bookkeeping for one TLB's global flush: holds the
// request level until the first ack and remembers that the ack arrived.
module tlb_flush_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic ack,
    output logic req,
    output logic acked
);

    logic req_q, req_d;
    logic acked_q, acked_d;

    always_comb begin
        req_d   = req_q;
        acked_d = acked_q;
        if (start) begin
            req_d   = 1'b1;
            acked_d = 1'b0;
        end else if (abort) begin
            req_d   = 1'b0;
            acked_d = 1'b0;
        end else if (req_q && ack) begin
            req_d   = 1'b0;
            acked_d = 1'b1;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            acked_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            acked_q <= acked_d;
        end
    end

    assign req = req_q;
    // A same-cycle ack already counts, so both sides can finish in one FLUSH cycle.
    assign acked = acked_q | (req_q & ack);

endmodule

// File: rtl/satp_update_sequencer.sv
// Owns the architectural satp: drains the pipeline and flushes both TLBs
// before a changed translation context is committed.
module satp_update_sequencer
    import harvos_satp_pkg::*;
#(
    parameter logic [31:0] SATP_RESET    = 32'h1000_0000,
    parameter logic [3:0]  SV_MODE       = SATP_MODE_SV,
    parameter int          FLUSH_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_wdata,
    output logic        drain_req,
    input  logic        pipe_empty,
    output logic        itlb_flush_req,
    input  logic        itlb_flush_ack,
    output logic        dtlb_flush_req,
    input  logic        dtlb_flush_ack,
    output logic [31:0] satp_q,
    output logic        done,
    output logic        reject,
    output logic        err,
    output logic        busy
);

    localparam int               CNT_W    = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

    satp_seq_state_e  state_q, state_d;
    logic [31:0]      pending_q, pending_d, satp_d;
    logic             rej_q, rej_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, reject_q, reject_d, err_q, err_d;
    logic             flush_start, flush_clear;
    logic             itlb_acked, dtlb_acked;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rej_d       = rej_q;
        satp_d      = satp_q;
        cnt_d       = '0;
        flush_start = 1'b0;
        flush_clear = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (wr_valid) begin
                    pending_d = satp_pack(SV_MODE, wr_wdata[SATP_CTX_W-1:0]);
                    rej_d     = wr_wdata[SATP_MODE_LSB +: SATP_MODE_W] != SV_MODE;
                    // A MODE-only change leaves translations intact: no flush.
                    state_d   = (pending_d[SATP_CTX_W-1:0] != satp_q[SATP_CTX_W-1:0])
                                ? SEQ_DRAIN : SEQ_COMMIT;
                end
            end
            SEQ_DRAIN: begin
                if (pipe_empty) begin
                    state_d     = SEQ_FLUSH;
                    flush_start = 1'b1;
                end
            end
            SEQ_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout wins even over an ack landing on the last cycle.
                if (cnt_q == CNT_LAST) begin
                    state_d     = SEQ_ABORT;
                    flush_clear = 1'b1;
                    cnt_d       = '0;
                end else if (itlb_acked && dtlb_acked) begin
                    state_d     = SEQ_COMMIT;
                    flush_clear = 1'b1;
                    cnt_d       = '0;
                end
            end
            SEQ_COMMIT: begin
                satp_d  = pending_q;
                state_d = SEQ_IDLE;
            end
            SEQ_ABORT: state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
        done_d   = (state_d == SEQ_COMMIT) || (state_d == SEQ_ABORT);
        reject_d = done_d && rej_d;
        err_d    = (state_d == SEQ_ABORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_IDLE;
            pending_q <= '0;
            rej_q     <= 1'b0;
            cnt_q     <= '0;
            satp_q    <= SATP_RESET;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rej_q     <= rej_d;
            cnt_q     <= cnt_d;
            satp_q    <= satp_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
            err_q     <= err_d;
        end
    end

    tlb_flush_tracker u_itlb (
        .clk   (clk),
        .rst_n (rst_n),
        .start (flush_start),
        .abort (flush_clear),
        .ack   (itlb_flush_ack),
        .req   (itlb_flush_req),
        .acked (itlb_acked)
    );

    tlb_flush_tracker u_dtlb (
        .clk   (clk),
        .rst_n (rst_n),
        .start (flush_start),
        .abort (flush_clear),
        .ack   (dtlb_flush_ack),
        .req   (dtlb_flush_req),
        .acked (dtlb_acked)
    );

    assign wr_ready  = (state_q == SEQ_IDLE);
    assign busy      = (state_q != SEQ_IDLE);
    assign drain_req = (state_q == SEQ_DRAIN) || (state_q == SEQ_FLUSH);
    assign done      = done_q;
    assign reject    = reject_q;
    assign err       = err_q;

endmodule

// File: doc/satp_update_sequencer.md
Name: satp_update_sequencer

Overview:
Sequences every CSR write to satp so a translation-context change is never visible with stale TLB contents. It accepts a write request, forces MODE to the only supported value, and drains the pipeline. It then runs a flush handshake with the I-TLB and D-TLB and commits the new satp only after both TLBs acknowledge. It sits between the CSR file write port and the MMU and is the single owner of the architectural satp register.

Parameters:
SATP_RESET, 32'h1000_0000, satp value after reset (MODE=1, ASID=0, PPN=0)
SV_MODE, 4'd1, the only legal MODE; written into satp[31:28] on every commit
FLUSH_TIMEOUT, 64, cycles allowed in FLUSH before abort; legal range 2..65535

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  CSR requests a satp write
wr_ready  out  1  sequencer can accept a write (high only in IDLE)
wr_wdata  in  32  requested satp value {MODE[3:0], ASID[5:0], PPN[21:0]}
drain_req  out  1  stall fetch/issue and drain in-flight memory ops
pipe_empty  in  1  pipeline has no in-flight translated accesses
itlb_flush_req  out  1  I-TLB global flush request (level, held until ack)
itlb_flush_ack  in  1  I-TLB flush complete (1-cycle pulse)
dtlb_flush_req  out  1  D-TLB global flush request
dtlb_flush_ack  in  1  D-TLB flush complete
satp_q  out  32  architectural satp
done  out  1  1-cycle pulse: request finished (committed or aborted)
reject  out  1  valid with done: requested MODE differed from SV_MODE
err  out  1  valid with done: flush timed out, satp unchanged
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert by the reset source): state=IDLE, satp_q=SATP_RESET, pending=0, all req/done/reject/err=0, busy=0, wr_ready=1.
- The request is accepted on the edge where wr_valid&wr_ready. The sequencer latches pending={SV_MODE, wr_wdata[27:0]} and rej_l=(wr_wdata[31:28]!=SV_MODE).
- Flush decision: need_flush = (pending[27:0] != satp_q[27:0]). A MODE-only difference never flushes.
- FSM states: IDLE, DRAIN, FLUSH, COMMIT, ABORT.
  - IDLE → COMMIT on accept when !need_flush. Latency from accept to done is 1 cycle.
  - IDLE → DRAIN on accept when need_flush.
  - DRAIN: drain_req=1. Moves to FLUSH on the first cycle pipe_empty is sampled high; stays indefinitely otherwise. drain_req stays high through FLUSH and deasserts on the COMMIT/ABORT exit.
  - FLUSH: on entry, itlb_flush_req=dtlb_flush_req=1 and the timeout counter is 0.
    - Each side has an ack-seen flag. An ack sampled while that side's req is high sets its flag, and that req drops the next cycle.
    - Acks arriving while req is low are ignored. Both acks in the same cycle are legal.
    - Both flags set → COMMIT.
    - If the counter reaches FLUSH_TIMEOUT-1 with a flag still clear → ABORT. This includes an ack landing on that same cycle; the timeout takes priority.
  - COMMIT: satp_q<=pending. done=1, reject=rej_l, err=0. Next state IDLE.
  - ABORT: satp_q unchanged. Both reqs drop. done=1, reject=rej_l, err=1. Next state IDLE.
- Minimum latency with a flush: accept → DRAIN → FLUSH (pipe_empty already high) → COMMIT, with acks on the first FLUSH cycle. done asserts 3 cycles after accept.
- wr_valid is ignored while busy. The CSR must hold the request until wr_ready.
- done, reject and err are registered outputs, 0 outside the done cycle.
- satp_q changes only in COMMIT. Reset asserted mid-sequence returns to the reset state immediately: the pending write is discarded and flush reqs drop asynchronously.
- Counter width is $clog2(FLUSH_TIMEOUT)+1. The counter is held at 0 outside FLUSH.

Decomposition:
- Package harvos_satp_pkg holds:
  - satp field offsets/widths: MODE [31:28], ASID [27:22], PPN [21:0]
  - SATP_MODE_SV=4'd1
  - the state enum satp_seq_state_e
- Sub-module tlb_flush_tracker: one per TLB (two instances). Inputs start/abort; outputs req and acked. It implements the req-hold/ack-latch for one side.
- The top level holds the FSM, pending register, timeout counter and satp_q.

Test Plan:
- Reset, then check satp_q=32'h1000_0000 and wr_ready=1. Write 32'h0480_0000 (MODE=0, ASID=0x12, PPN=0) → reject=1 with done; satp_q=32'h1480_0000; both flush reqs seen; done 3 cycles after accept with immediate acks and pipe_empty=1.
- Write 32'h10CA_BCDE with pipe_empty held low 5 cycles → drain_req high for those cycles, no flush req until pipe_empty=1, then commit satp_q=32'h10CA_BCDE.
- Rewrite identical 32'h10CA_BCDE → no drain_req, no flush req, done 1 cycle after accept, reject=0.
- FLUSH with itlb_ack at +1 and dtlb_ack at +7 → itlb_flush_req drops after its ack while dtlb_flush_req stays high; commit after the dtlb ack. A stray itlb_ack at +4 has no effect.
- Withhold dtlb_ack with FLUSH_TIMEOUT=8 → done with err=1 on abort, satp_q unchanged, both reqs low, wr_ready=1 next cycle.
- Assert rst_n=0 mid-FLUSH → reqs drop without waiting for the clock, satp_q=SATP_RESET. After release, wr_valid pulsed while busy is ignored and no second request is accepted.
